// File: rtl/tt_vector_sequencer.sv
// Vector-table sequencer for a TinyTapeout-style DUT: resets the DUT once, then applies each
// table vector, waits a settle time, and compares the DUT outputs under a per-vector mask.
module tt_vector_sequencer #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned DUT_RST_CYC = 8,
  parameter int unsigned SETTLE_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              step_mode,
  input  logic              step,
  output logic [ADDR_W-1:0] vec_addr,
  input  logic [15:0]       vec_stim,
  input  logic [15:0]       vec_expect,
  input  logic [15:0]       vec_mask,
  output logic [7:0]        dut_ui_in,
  output logic [7:0]        dut_uio_in,
  output logic              dut_ena,
  output logic              dut_rst_n,
  input  logic [7:0]        dut_uo_out,
  input  logic [7:0]        dut_uio_out,
  input  logic [7:0]        dut_uio_oe,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] fail_idx,
  output logic [ADDR_W-1:0] cur_idx
);

  localparam int unsigned MAX_CYC = (DUT_RST_CYC > SETTLE_CYC) ? DUT_RST_CYC : SETTLE_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  RST_END  = CNT_W'(DUT_RST_CYC - 1);
  localparam logic [CNT_W-1:0]  SET_END  = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DUT_RST, S_FETCH, S_APPLY, S_SETTLE, S_CHECK, S_WAIT_STEP, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] cur_idx_q, cur_idx_d;
  logic [ADDR_W-1:0] fail_idx_q, fail_idx_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [15:0]       stim_q, stim_d;
  logic [15:0]       exp_q, exp_d;
  logic [15:0]       mask_q, mask_d;
  logic              dut_rst_n_q, dut_rst_n_d;
  logic              dut_ena_q, dut_ena_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mismatch_c;
  logic              unused_oe;

  // Output-enable is informational only; uio bits the DUT leaves undriven are masked in the table.
  assign unused_oe  = ^dut_uio_oe;
  assign mismatch_c = |(({dut_uio_out, dut_uo_out} ^ exp_q) & mask_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cur_idx_q   <= '0;
      fail_idx_q  <= '0;
      err_count_q <= '0;
      stim_q      <= '0;
      exp_q       <= '0;
      mask_q      <= '0;
      dut_rst_n_q <= 1'b0;
      dut_ena_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cur_idx_q   <= cur_idx_d;
      fail_idx_q  <= fail_idx_d;
      err_count_q <= err_count_d;
      stim_q      <= stim_d;
      exp_q       <= exp_d;
      mask_q      <= mask_d;
      dut_rst_n_q <= dut_rst_n_d;
      dut_ena_q   <= dut_ena_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Next state, phase counter and vector index.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_idx_d = cur_idx_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d   = S_DUT_RST;
            cnt_d     = '0;
            cur_idx_d = '0;
          end
        end
        S_DUT_RST: begin
          if (cnt_q == RST_END) state_d = S_FETCH;
          else                  cnt_d   = cnt_q + CNT_W'(1);
        end
        S_FETCH: state_d = S_APPLY;
        S_APPLY: begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end
        S_SETTLE: begin
          if (cnt_q == SET_END) state_d = S_CHECK;
          else                  cnt_d   = cnt_q + CNT_W'(1);
        end
        S_CHECK: begin
          if (cur_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else if (step_mode) begin
            state_d = S_WAIT_STEP;
          end else begin
            state_d   = S_FETCH;
            cur_idx_d = cur_idx_q + ADDR_W'(1);
          end
        end
        S_WAIT_STEP: begin
          if (step || !step_mode) begin
            state_d   = S_FETCH;
            cur_idx_d = cur_idx_q + ADDR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    stim_d      = stim_q;
    exp_d       = exp_q;
    mask_d      = mask_q;
    err_count_d = err_count_q;
    fail_idx_d  = fail_idx_q;
    busy_d      = state_d inside {S_DUT_RST, S_FETCH, S_APPLY, S_SETTLE, S_CHECK, S_WAIT_STEP};
    done_d      = (state_d == S_DONE);
    dut_ena_d   = (state_d != S_IDLE);

    case (state_d)
      S_IDLE, S_DUT_RST: dut_rst_n_d = 1'b0;
      S_FETCH:           dut_rst_n_d = dut_rst_n_q;
      default:           dut_rst_n_d = 1'b1;
    endcase

    if (state_d == S_IDLE || state_d == S_DUT_RST) begin
      stim_d = '0;
    end else if (state_q == S_APPLY) begin
      stim_d = vec_stim;
      exp_d  = vec_expect;
      mask_d = vec_mask;
    end

    if (!abort && state_q == S_DONE && start) begin
      err_count_d = '0;
      fail_idx_d  = '0;
    end else if (!abort && state_q == S_CHECK && mismatch_c) begin
      if (err_count_q == '0)    fail_idx_d  = cur_idx_q;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end

    pass_d = done_d && (err_count_d == '0);
  end

  assign vec_addr   = cur_idx_q;
  assign cur_idx    = cur_idx_q;
  assign fail_idx   = fail_idx_q;
  assign err_count  = err_count_q;
  assign dut_ui_in  = stim_q[7:0];
  assign dut_uio_in = stim_q[15:8];
  assign dut_rst_n  = dut_rst_n_q;
  assign dut_ena    = dut_ena_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;

endmodule
